memory_arbiter: RTL and testbench

//  Shares the single-ported memory_controller between instruction fetch (IF) and the

---
 rtl/memory_arbiter.sv | 160 ++++++++++++++++
 tb/tb_memory_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : memory_arbiter
// Shares the single memory port between instruction fetch and the data port.
// Optional IF starvation guard: define MEMORY_ARBITER_STARVE_GUARD_EN.
// Revision : 1.0
// ============================================================================
module memory_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              n_reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_abort,
   input  logic              d_req,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic [1:0]        d_size,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_abort,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] rdata,
   input  logic              abort,
   output logic              write,
   output logic [1:0]        size,
   output logic [1:0]        prot,
   output logic [1:0]        trans
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic       OWN_IF     = 1'b0;
   localparam logic       OWN_D      = 1'b1;
   localparam logic [1:0] TRANS_IDLE = 2'b00;
   localparam logic [1:0] TRANS_ACC  = 2'b11;
   localparam logic [1:0] SIZE_WORD  = 2'b10;
   localparam logic [1:0] PROT_IF    = 2'b10;
   localparam logic [1:0] PROT_D     = 2'b11;

   state_t state, state_nxt;
   logic   owner;
   logic   arb_point;
   logic   any_req;
   logic   d_wins;

   generate
      if (STARVE_LIMIT < 1) begin : g_bad_limit
         $error("memory_arbiter: STARVE_LIMIT must be at least 1");
      end
   endgenerate

   assign arb_point = (state == IDLE) || (state == RESP);
   assign any_req   = if_req | d_req;

`ifdef MEMORY_ARBITER_STARVE_GUARD_EN
   localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] starve_cnt;
   logic             force_if;

   assign force_if = if_req && (starve_cnt == CNT_MAX);
   assign d_wins   = d_req && !force_if;

   // Counts consecutive arbitration points that IF lost while requesting.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         starve_cnt <= '0;
      end else if (arb_point) begin
         if (!if_req || !d_wins) begin
            starve_cnt <= '0;
         end else if (starve_cnt != CNT_MAX) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
         end
      end
   end
`else
   assign d_wins = d_req;
`endif

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, RESP: state_nxt = any_req ? ACCESS : IDLE;
         ACCESS:     state_nxt = RESP;
         default:    state_nxt = IDLE;
      endcase
   end

   // Bus and grant registers: everything defaults back to idle each cycle,
   // so write and the grants can only be high for the single ACCESS cycle.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         trans  <= TRANS_IDLE;
         write  <= 1'b0;
         addr   <= '0;
         wdata  <= '0;
         size   <= SIZE_WORD;
         prot   <= PROT_IF;
         if_gnt <= 1'b0;
         d_gnt  <= 1'b0;
         owner  <= OWN_IF;
      end else begin
         trans  <= TRANS_IDLE;
         write  <= 1'b0;
         if_gnt <= 1'b0;
         d_gnt  <= 1'b0;
         if (arb_point && any_req) begin
            trans <= TRANS_ACC;
            if (d_wins) begin
               addr  <= d_addr;
               wdata <= d_wdata;
               write <= d_write;
               size  <= d_size;
               prot  <= PROT_D;
               d_gnt <= 1'b1;
               owner <= OWN_D;
            end else begin
               addr   <= if_addr;
               wdata  <= '0;
               size   <= SIZE_WORD;
               prot   <= PROT_IF;
               if_gnt <= 1'b1;
               owner  <= OWN_IF;
            end
         end
      end
   end

   assign if_rvalid = (state == RESP) && (owner == OWN_IF);
   assign d_rvalid  = (state == RESP) && (owner == OWN_D);
   assign if_rdata  = if_rvalid ? rdata : '0;
   assign d_rdata   = d_rvalid ? rdata : '0;
   assign if_abort  = if_rvalid & abort;
   assign d_abort   = d_rvalid & abort;

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_arbiter
// Randomized requesters checked cycle by cycle against a transaction-level
// model of the arbiter and a reference memory.
// Revision : 1.0
// ============================================================================
module tb_memory_arbiter;

   localparam int ADDR_W       = 32;
   localparam int DATA_W       = 32;
   localparam int STARVE_LIMIT = 4;

   logic              clk = 1'b0;
   logic              n_reset = 1'b0;
   logic              if_req = 1'b0;
   logic [ADDR_W-1:0] if_addr = '0;
   logic              if_gnt, if_rvalid, if_abort;
   logic [DATA_W-1:0] if_rdata;
   logic              d_req = 1'b0;
   logic              d_write = 1'b0;
   logic [ADDR_W-1:0] d_addr = '0;
   logic [DATA_W-1:0] d_wdata = '0;
   logic [1:0]        d_size = 2'b10;
   logic              d_gnt, d_rvalid, d_abort;
   logic [DATA_W-1:0] d_rdata;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata = '0;
   logic              abort = 1'b0;
   logic              write;
   logic [1:0]        size, prot, trans;

   memory_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)
   ) dut (
      .clk(clk), .n_reset(n_reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
      .if_rdata(if_rdata), .if_abort(if_abort),
      .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_size(d_size), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .d_abort(d_abort),
      .addr(addr), .wdata(wdata), .rdata(rdata), .abort(abort),
      .write(write), .size(size), .prot(prot), .trans(trans)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: one slot, either free (arbitration) or holding an access.
   logic [31:0] ref_mem [256];
   bit          busy;
   bit          acc_d, acc_write;
   logic [31:0] acc_addr, acc_wdata;
   logic [1:0]  acc_size;
   logic [7:0]  abort_addr = 8'hFF;
   bit          g_if, g_d;
`ifdef MEMORY_ARBITER_STARVE_GUARD_EN
   int          starve;
`endif

   logic [1:0]  e_trans, e_size, e_prot;
   logic        e_write, e_if_gnt, e_d_gnt, e_if_rvalid, e_d_rvalid, e_if_abort, e_d_abort;
   logic [31:0] e_addr, e_wdata, e_if_rdata, e_d_rdata;

   typedef struct packed {
      logic        w;
      logic [31:0] a;
      logic [31:0] d;
   } dreq_t;

   bit          if_active, d_active;
   int          p_if = 0, p_d = 0;
   logic [31:0] if_q[$];
   dreq_t       d_q[$];

   task automatic clear_expect();
      e_trans = 2'b00; e_write = 1'b0; e_if_gnt = 1'b0; e_d_gnt = 1'b0;
      e_if_rvalid = 1'b0; e_d_rvalid = 1'b0; e_if_abort = 1'b0; e_d_abort = 1'b0;
      e_if_rdata = '0; e_d_rdata = '0; e_addr = '0; e_wdata = '0;
      e_size = 2'b10; e_prot = 2'b10;
   endtask

   task automatic model_reset();
      busy = 1'b0; g_if = 1'b0; g_d = 1'b0;
`ifdef MEMORY_ARBITER_STARVE_GUARD_EN
      starve = 0;
`endif
      clear_expect();
   endtask

   task automatic check_reset_values();
      check_value("rst_trans", trans, 2'b00);
      check_value("rst_write", write, 1'b0);
      check_value("rst_addr", addr, 32'h0);
      check_value("rst_wdata", wdata, 32'h0);
      check_value("rst_size", size, 2'b10);
      check_value("rst_prot", prot, 2'b10);
      check_value("rst_gnts", {if_gnt, d_gnt}, 2'b00);
      check_value("rst_rvalids", {if_rvalid, d_rvalid}, 2'b00);
      check_value("rst_aborts", {if_abort, d_abort}, 2'b00);
      check_value("rst_if_rdata", if_rdata, 32'h0);
      check_value("rst_d_rdata", d_rdata, 32'h0);
   endtask

   task automatic check_outputs();
      check_value("trans", trans, e_trans);
      check_value("write", write, e_write);
      check_value("if_gnt", if_gnt, e_if_gnt);
      check_value("d_gnt", d_gnt, e_d_gnt);
      check_value("if_rvalid", if_rvalid, e_if_rvalid);
      check_value("d_rvalid", d_rvalid, e_d_rvalid);
      check_value("if_rdata", if_rdata, e_if_rdata);
      check_value("d_rdata", d_rdata, e_d_rdata);
      check_value("if_abort", if_abort, e_if_abort);
      check_value("d_abort", d_abort, e_d_abort);
      if (e_trans == 2'b11) begin
         check_value("addr", addr, e_addr);
         check_value("prot", prot, e_prot);
         check_value("size", size, e_size);
         if (acc_d) check_value("wdata", wdata, e_wdata);
      end
   endtask

   // Requesters: hold fields until the model says they were granted.
   task automatic drive_agents();
      dreq_t r;
      if (g_if) if_active = 1'b0;
      if (g_d)  d_active  = 1'b0;
      if (!if_active) begin
         if (if_q.size() > 0) begin
            if_addr = if_q.pop_front(); if_active = 1'b1;
         end else if (int'($urandom_range(99)) < p_if) begin
            if_addr = 32'($urandom_range(31)); if_active = 1'b1;
         end else begin
            if_addr = $urandom;
         end
      end
      if (!d_active) begin
         if (d_q.size() > 0) begin
            r = d_q.pop_front();
            d_write = r.w; d_addr = r.a; d_wdata = r.d; d_size = 2'b10; d_active = 1'b1;
         end else if (int'($urandom_range(99)) < p_d) begin
            d_write = 1'($urandom_range(1)); d_addr = 32'($urandom_range(31));
            d_wdata = $urandom; d_size = 2'($urandom_range(3)); d_active = 1'b1;
         end else begin
            d_write = 1'($urandom_range(1)); d_addr = $urandom; d_wdata = $urandom;
         end
      end
      if_req = if_active;
      d_req  = d_active;
   endtask

   // Predicts the effect of the coming clock edge and drives the memory side.
   task automatic model_step();
      bit          take_d, ab;
      logic [31:0] data;
      g_if = 1'b0; g_d = 1'b0;
      clear_expect();
      rdata = $urandom;
      abort = 1'($urandom_range(1));
      if (!busy) begin
         if (if_req || d_req) begin
            take_d = d_req;
`ifdef MEMORY_ARBITER_STARVE_GUARD_EN
            if (if_req && starve >= STARVE_LIMIT) take_d = 1'b0;
            if (if_req && take_d) starve = starve + 1;
            else starve = 0;
`endif
            acc_d     = take_d;
            acc_write = take_d ? d_write : 1'b0;
            acc_addr  = take_d ? d_addr : if_addr;
            acc_wdata = d_wdata;
            acc_size  = take_d ? d_size : 2'b10;
            busy = 1'b1; g_d = take_d; g_if = !take_d;
            e_trans = 2'b11; e_write = acc_write; e_addr = acc_addr; e_wdata = acc_wdata;
            e_size = acc_size; e_prot = {1'b1, take_d};
            e_if_gnt = !take_d; e_d_gnt = take_d;
         end else begin
`ifdef MEMORY_ARBITER_STARVE_GUARD_EN
            starve = 0;
`endif
         end
      end else begin
         ab = (acc_addr == {24'h0, abort_addr});
         if (acc_write) begin
            if (!ab) ref_mem[acc_addr[7:0]] = acc_wdata;
            data = '0;
         end else begin
            data = ab ? 32'hBAD0_0000 : ref_mem[acc_addr[7:0]];
         end
         rdata = data; abort = ab;
         if (acc_d) begin
            e_d_rvalid = 1'b1; e_d_rdata = data; e_d_abort = ab;
         end else begin
            e_if_rvalid = 1'b1; e_if_rdata = data; e_if_abort = ab;
         end
         busy = 1'b0;
      end
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check_outputs();
         drive_agents();
         model_step();
      end
   endtask

   task automatic push_d(input logic w, input logic [31:0] a, input logic [31:0] d);
      dreq_t r;
      r.w = w; r.a = a; r.d = d;
      d_q.push_back(r);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
      rdata = 32'hA5A5_A5A5;
      abort = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      check_reset_values();
      n_reset = 1'b1;

      // IF fetch of a known word
      ref_mem[8'h10] = 32'hDEADBEEF;
      if_q.push_back(32'h10);
      run_cycles(5);

      // store then load through the data port
      push_d(1'b1, 32'h20, 32'h12345678);
      push_d(1'b0, 32'h20, 32'h0);
      run_cycles(8);

      // simultaneous requests: D first, IF next
      if_q.push_back(32'h11);
      push_d(1'b0, 32'h10, 32'h0);
      run_cycles(8);

      // continuous D traffic with IF waiting
      p_d = 100;
      if_q.push_back(32'h12);
      run_cycles(24);
      p_d = 0;
      run_cycles(8);

      // memory abort on a D load
      abort_addr = 8'h33;
      push_d(1'b0, 32'h33, 32'h0);
      run_cycles(5);

      // randomized mixed traffic
      abort_addr = 8'h05;
      p_if = 50; p_d = 50;
      run_cycles(400);
      p_if = 0; p_d = 0;
      run_cycles(8);

      // reset asserted during ACCESS
      push_d(1'b0, 32'h10, 32'h0);
      for (int k = 0; k < 10 && !busy; k++) run_cycles(1);
      @(posedge clk);
      #2;
      check_value("pre_rst_trans", trans, 2'b11);
      check_value("pre_rst_d_gnt", d_gnt, 1'b1);
      n_reset = 1'b0;
      #1;
      check_reset_values();
      @(posedge clk);
      #1;
      check_value("rst_hold_d_rvalid", d_rvalid, 1'b0);
      check_value("rst_hold_trans", trans, 2'b00);
      @(negedge clk);
      if_active = 1'b0; d_active = 1'b0; if_req = 1'b0; d_req = 1'b0;
      if_q.delete(); d_q.delete();
      model_reset();
      n_reset = 1'b1;
      push_d(1'b0, 32'h10, 32'h0);
      if_q.push_back(32'h20);
      run_cycles(8);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout expected=completion");
      $fatal(1, "simulation time limit reached");
   end

endmodule
`default_nettype wire
